// File: rtl/rcv_pkg.sv
// Shared encodings for the receive FIFO controller: AHB transfer types and
// the write-side FSM states.
package rcv_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        W_IDLE  = 3'd0,
        W_DATA  = 3'd1,
        W_STALL = 3'd2,
        W_ERR1  = 3'd3,
        W_ERR2  = 3'd4
    } rcv_wstate_t;

endpackage

// File: rtl/rcv_drain_ctrl.sv
// Drain side of the receive FIFO: presents the head block to the cipher core
// and pops it on acceptance, at most once every two cycles.
module rcv_drain_ctrl #(
    parameter int BLK_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 empty_i,
    input  logic                 blk_ready_i,
    output logic                 blk_valid_o,
    output logic                 rcv_deq_o,
    output logic [BLK_CNT_W-1:0] blk_cnt_o
);

    logic                 drain_hold_q, drain_hold_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    // Handshake: a block moves when blk_valid and blk_ready are both high in
    // the same cycle; the hold cycle that follows masks the stale empty flag.
    always_comb begin
        blk_valid_o  = ~empty_i & ~drain_hold_q;
        rcv_deq_o    = blk_valid_o & blk_ready_i;
        drain_hold_d = rcv_deq_o;
        blk_cnt_d    = blk_cnt_q + {{(BLK_CNT_W-1){1'b0}}, rcv_deq_o};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drain_hold_q <= 1'b0;
            blk_cnt_q    <= '0;
        end else begin
            drain_hold_q <= drain_hold_d;
            blk_cnt_q    <= blk_cnt_d;
        end
    end

    assign blk_cnt_o = blk_cnt_q;

endmodule

// File: rtl/rcv_fifo_ctrl.sv
// Receive FIFO controller: AHB-Lite write decode with full-FIFO stall and
// watchdog, framing-error recovery, and the block drain handshake.
module rcv_fifo_ctrl
    import rcv_pkg::*;
#(
    parameter int BLK_CNT_W = 8,
    parameter int WATCHDOG  = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 HSEL,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    input  logic                 full,
    input  logic                 empty,
    input  logic                 framing_error,
    output logic                 rcv_enq_word,
    output logic                 rcv_deq,
    output logic                 fix_error,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic                 err_sticky,
    input  logic                 err_clr,
    output logic [BLK_CNT_W-1:0] blk_cnt,
    output logic [2:0]           dbg_state_o
);

    localparam int CNT_W = $clog2(WATCHDOG + 1);

    rcv_wstate_t      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, stall_inc;
    logic             err_q, err_d;
    htrans_t          trans;
    logic             accept;

    assign trans     = htrans_t'(HTRANS);
    assign accept    = HSEL & HWRITE & HREADY &
                       ((trans == HTRANS_NONSEQ) | (trans == HTRANS_SEQ));
    assign stall_inc = stall_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        rcv_enq_word = 1'b0;
        HREADYOUT    = 1'b1;
        HRESP        = 1'b0;
        fix_error    = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (framing_error)  state_d = W_ERR1;
                else if (accept)    state_d = W_DATA;
            end
            W_DATA, W_STALL: begin
                if (!full) begin
                    // The enqueue completes even when a framing error arrives now.
                    rcv_enq_word = 1'b1;
                    if (framing_error) state_d = W_ERR1;
                    else if (accept)   state_d = W_DATA;
                    else               state_d = W_IDLE;
                end else begin
                    HREADYOUT = 1'b0;
                    if (framing_error)                      state_d = W_ERR1;
                    else if (state_q == W_DATA)             state_d = W_STALL;
                    else if (stall_inc == CNT_W'(WATCHDOG)) state_d = W_ERR1;
                end
            end
            W_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                fix_error = 1'b1;
                state_d   = W_ERR2;
            end
            W_ERR2: begin
                HRESP   = 1'b1;
                state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
        stall_cnt_d = ((state_q == W_STALL) && (state_d == W_STALL)) ? stall_inc : '0;
        err_d       = (state_q == W_ERR1) | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= W_IDLE;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign err_sticky  = err_q;
    assign dbg_state_o = state_q;

    rcv_drain_ctrl #(
        .BLK_CNT_W (BLK_CNT_W)
    ) u_drain (
        .clk         (clk),
        .n_rst       (n_rst),
        .empty_i     (empty),
        .blk_ready_i (blk_ready),
        .blk_valid_o (blk_valid),
        .rcv_deq_o   (rcv_deq),
        .blk_cnt_o   (blk_cnt)
    );

endmodule

// File: tb/tb_rcv_fifo_ctrl.sv
// Directed bench for rcv_fifo_ctrl: a default-watchdog instance for the main
// scenarios and a WATCHDOG=4 instance for the watchdog trip.
module tb_rcv_fifo_ctrl;
    import rcv_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       hsel, hwrite, full, empty, framing_error, blk_ready, err_clr;
    logic [1:0] htrans;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       hready, hreadyout, hresp, enq, deq, fix, blk_valid, err_st;
    logic [7:0] blk_cnt;
    logic [2:0] state;
    logic       hready_w, hreadyout_w, hresp_w, enq_w, deq_w, fix_w, blk_valid_w, err_st_w;
    logic [7:0] blk_cnt_w;
    logic [2:0] state_w;

    // Single slave on the bus, so its own HREADYOUT is the bus HREADY.
    assign hready   = hreadyout;
    assign hready_w = hreadyout_w;

    always #5 clk = ~clk;

    rcv_fifo_ctrl #(.BLK_CNT_W(8), .WATCHDOG(16)) u_dut (
        .clk(clk), .n_rst(n_rst), .HSEL(hsel), .HWRITE(hwrite), .HTRANS(htrans),
        .HREADY(hready), .HREADYOUT(hreadyout), .HRESP(hresp), .full(full), .empty(empty),
        .framing_error(framing_error), .rcv_enq_word(enq), .rcv_deq(deq), .fix_error(fix),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .err_sticky(err_st), .err_clr(err_clr),
        .blk_cnt(blk_cnt), .dbg_state_o(state)
    );

    rcv_fifo_ctrl #(.BLK_CNT_W(8), .WATCHDOG(4)) u_dut_wd (
        .clk(clk), .n_rst(n_rst), .HSEL(hsel), .HWRITE(hwrite), .HTRANS(htrans),
        .HREADY(hready_w), .HREADYOUT(hreadyout_w), .HRESP(hresp_w), .full(full), .empty(empty),
        .framing_error(framing_error), .rcv_enq_word(enq_w), .rcv_deq(deq_w), .fix_error(fix_w),
        .blk_valid(blk_valid_w), .blk_ready(blk_ready), .err_sticky(err_st_w), .err_clr(err_clr),
        .blk_cnt(blk_cnt_w), .dbg_state_o(state_w)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        hwrite = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    task automatic bus_write(input logic [1:0] t);
        hsel   = 1'b1;
        hwrite = 1'b1;
        htrans = t;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (hreadyout !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout: got %b want 1", hreadyout); end
        n_cmp++; if (hresp !== 1'b0) begin n_bad++; $display("FAIL reset_hresp: got %b want 0", hresp); end
        n_cmp++; if (enq !== 1'b0) begin n_bad++; $display("FAIL reset_enq: got %b want 0", enq); end
        n_cmp++; if (deq !== 1'b0) begin n_bad++; $display("FAIL reset_deq: got %b want 0", deq); end
        n_cmp++; if (fix !== 1'b0) begin n_bad++; $display("FAIL reset_fix: got %b want 0", fix); end
        n_cmp++; if (err_st !== 1'b0) begin n_bad++; $display("FAIL reset_err_sticky: got %b want 0", err_st); end
        n_cmp++; if (blk_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt); end
        n_cmp++; if (state !== W_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state, W_IDLE); end
        step();
        n_rst = 1'b1;
    endtask

    task automatic test_single_write();
        step(); bus_write(HTRANS_NONSEQ); full = 1'b0; #1;
        n_cmp++; if (enq !== 1'b0) begin n_bad++; $display("FAIL single_addr_enq: got %b want 0", enq); end
        step(); bus_idle(); #1;
        n_cmp++; if (enq !== 1'b1) begin n_bad++; $display("FAIL single_data_enq: got %b want 1", enq); end
        n_cmp++; if (hreadyout !== 1'b1) begin n_bad++; $display("FAIL single_data_hreadyout: got %b want 1", hreadyout); end
        n_cmp++; if (state !== W_DATA) begin n_bad++; $display("FAIL single_data_state: got %0d want %0d", state, W_DATA); end
        step(); #1;
        n_cmp++; if (enq !== 1'b0) begin n_bad++; $display("FAIL single_after_enq: got %b want 0", enq); end
        n_cmp++; if (state !== W_IDLE) begin n_bad++; $display("FAIL single_after_state: got %0d want %0d", state, W_IDLE); end
    endtask

    task automatic test_burst();
        logic [5:0] sel_v   = 6'b001111;
        logic [5:0] seq_v   = 6'b001110;
        logic [5:0] empty_v = 6'b101111;
        logic [5:0] exp_enq = 6'b011110;
        logic [5:0] exp_deq = 6'b010000;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sel_v[i]) bus_write(seq_v[i] ? HTRANS_SEQ : HTRANS_NONSEQ);
            else          bus_idle();
            empty     = empty_v[i];
            blk_ready = 1'b1;
            #1;
            n_cmp++; if (enq !== exp_enq[i]) begin n_bad++; $display("FAIL burst_enq[%0d]: got %b want %b", i, enq, exp_enq[i]); end
            n_cmp++; if (deq !== exp_deq[i]) begin n_bad++; $display("FAIL burst_deq[%0d]: got %b want %b", i, deq, exp_deq[i]); end
            n_cmp++; if (hreadyout !== 1'b1) begin n_bad++; $display("FAIL burst_hreadyout[%0d]: got %b want 1", i, hreadyout); end
        end
        n_cmp++; if (blk_cnt !== 8'd1) begin n_bad++; $display("FAIL burst_blk_cnt: got %0d want 1", blk_cnt); end
        blk_ready = 1'b0;
        empty     = 1'b1;
    endtask

    task automatic test_backpressure();
        step(); bus_write(HTRANS_NONSEQ); full = 1'b0; #1;
        n_cmp++; if (enq !== 1'b0) begin n_bad++; $display("FAIL bp_addr_enq: got %b want 0", enq); end
        for (int i = 0; i < 5; i++) begin
            step(); bus_idle(); full = 1'b1; #1;
            n_cmp++; if (hreadyout !== 1'b0) begin n_bad++; $display("FAIL bp_hreadyout[%0d]: got %b want 0", i, hreadyout); end
            n_cmp++; if (enq !== 1'b0) begin n_bad++; $display("FAIL bp_enq[%0d]: got %b want 0", i, enq); end
        end
        n_cmp++; if (state !== W_STALL) begin n_bad++; $display("FAIL bp_state: got %0d want %0d", state, W_STALL); end
        step(); full = 1'b0; #1;
        n_cmp++; if (hreadyout !== 1'b1) begin n_bad++; $display("FAIL bp_release_hreadyout: got %b want 1", hreadyout); end
        n_cmp++; if (enq !== 1'b1) begin n_bad++; $display("FAIL bp_release_enq: got %b want 1", enq); end
        step(); #1;
        n_cmp++; if (state !== W_IDLE) begin n_bad++; $display("FAIL bp_after_state: got %0d want %0d", state, W_IDLE); end
    endtask

    task automatic test_watchdog();
        rcv_wstate_t exp_st [9] = '{W_IDLE, W_DATA, W_STALL, W_STALL, W_STALL, W_STALL, W_ERR1, W_ERR2, W_IDLE};
        logic [8:0] exp_rdy  = 9'b110000001;
        logic [8:0] exp_resp = 9'b011000000;
        logic [8:0] exp_fix  = 9'b001000000;
        logic [8:0] exp_err  = 9'b110000000;
        step(); n_rst = 1'b0; #1; n_rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) begin bus_write(HTRANS_NONSEQ); full = 1'b0; end
            else        begin bus_idle(); full = 1'b1; end
            #1;
            n_cmp++; if (state_w !== exp_st[i]) begin n_bad++; $display("FAIL wd_state[%0d]: got %0d want %0d", i, state_w, exp_st[i]); end
            n_cmp++; if (hreadyout_w !== exp_rdy[i]) begin n_bad++; $display("FAIL wd_hreadyout[%0d]: got %b want %b", i, hreadyout_w, exp_rdy[i]); end
            n_cmp++; if (hresp_w !== exp_resp[i]) begin n_bad++; $display("FAIL wd_hresp[%0d]: got %b want %b", i, hresp_w, exp_resp[i]); end
            n_cmp++; if (fix_w !== exp_fix[i]) begin n_bad++; $display("FAIL wd_fix[%0d]: got %b want %b", i, fix_w, exp_fix[i]); end
            n_cmp++; if (enq_w !== 1'b0) begin n_bad++; $display("FAIL wd_enq[%0d]: got %b want 0", i, enq_w); end
            n_cmp++; if (err_st_w !== exp_err[i]) begin n_bad++; $display("FAIL wd_err_sticky[%0d]: got %b want %b", i, err_st_w, exp_err[i]); end
        end
        step(); full = 1'b0; err_clr = 1'b1;
        step(); err_clr = 1'b0;
        step(); #1;
        n_cmp++; if (state !== W_IDLE) begin n_bad++; $display("FAIL wd_main_state: got %0d want %0d", state, W_IDLE); end
    endtask

    task automatic test_framing();
        step(); framing_error = 1'b1; #1;
        n_cmp++; if (hresp !== 1'b0) begin n_bad++; $display("FAIL fe_idle_hresp: got %b want 0", hresp); end
        step(); framing_error = 1'b0; err_clr = 1'b1; #1;
        n_cmp++; if (state !== W_ERR1) begin n_bad++; $display("FAIL fe_err1_state: got %0d want %0d", state, W_ERR1); end
        n_cmp++; if (fix !== 1'b1) begin n_bad++; $display("FAIL fe_err1_fix: got %b want 1", fix); end
        n_cmp++; if (hresp !== 1'b1 || hreadyout !== 1'b0) begin n_bad++; $display("FAIL fe_err1_resp: got hresp=%b hreadyout=%b want 1 0", hresp, hreadyout); end
        step(); err_clr = 1'b0; #1;
        n_cmp++; if (state !== W_ERR2) begin n_bad++; $display("FAIL fe_err2_state: got %0d want %0d", state, W_ERR2); end
        n_cmp++; if (hresp !== 1'b1 || hreadyout !== 1'b1 || fix !== 1'b0) begin n_bad++; $display("FAIL fe_err2_resp: got hresp=%b hreadyout=%b fix=%b want 1 1 0", hresp, hreadyout, fix); end
        n_cmp++; if (err_st !== 1'b1) begin n_bad++; $display("FAIL fe_set_wins: got %b want 1", err_st); end
        step(); err_clr = 1'b1; #1;
        n_cmp++; if (state !== W_IDLE || hresp !== 1'b0) begin n_bad++; $display("FAIL fe_back_idle: got state=%0d hresp=%b want %0d 0", state, hresp, W_IDLE); end
        n_cmp++; if (err_st !== 1'b1) begin n_bad++; $display("FAIL fe_sticky_hold: got %b want 1", err_st); end
        step(); err_clr = 1'b0; #1;
        n_cmp++; if (err_st !== 1'b0) begin n_bad++; $display("FAIL fe_sticky_clr: got %b want 0", err_st); end
        step(); bus_write(HTRANS_NONSEQ); #1;
        step(); bus_idle(); framing_error = 1'b1; #1;
        n_cmp++; if (enq !== 1'b1) begin n_bad++; $display("FAIL fe_enq_wins: got %b want 1", enq); end
        step(); framing_error = 1'b0; #1;
        n_cmp++; if (state !== W_ERR1 || enq !== 1'b0) begin n_bad++; $display("FAIL fe_deferred_err1: got state=%0d enq=%b want %0d 0", state, enq, W_ERR1); end
        step(); step(); err_clr = 1'b1;
        step(); err_clr = 1'b0; #1;
        n_cmp++; if (state !== W_IDLE || err_st !== 1'b0) begin n_bad++; $display("FAIL fe_recover: got state=%0d err=%b want %0d 0", state, err_st, W_IDLE); end
    endtask

    task automatic test_drain_spacing();
        logic [4:0] empty_v = 5'b11000;
        logic [4:0] exp_deq = 5'b00101;
        for (int i = 0; i < 5; i++) begin
            step(); empty = empty_v[i]; blk_ready = 1'b1; #1;
            n_cmp++; if (deq !== exp_deq[i]) begin n_bad++; $display("FAIL drain_deq[%0d]: got %b want %b", i, deq, exp_deq[i]); end
            n_cmp++; if (blk_valid !== exp_deq[i]) begin n_bad++; $display("FAIL drain_valid[%0d]: got %b want %b", i, blk_valid, exp_deq[i]); end
        end
        n_cmp++; if (blk_cnt !== 8'd2) begin n_bad++; $display("FAIL drain_blk_cnt: got %0d want 2", blk_cnt); end
    endtask

    task automatic test_cnt_wrap();
        for (int k = 0; k < 506; k++) begin
            step(); empty = 1'b0; blk_ready = 1'b1;
        end
        step(); #1;
        n_cmp++; if (blk_cnt !== 8'd255) begin n_bad++; $display("FAIL wrap_cnt_255: got %0d want 255", blk_cnt); end
        n_cmp++; if (deq !== 1'b1) begin n_bad++; $display("FAIL wrap_deq: got %b want 1", deq); end
        step(); #1;
        n_cmp++; if (blk_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_cnt_0: got %0d want 0", blk_cnt); end
        empty = 1'b1; blk_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        step(); bus_write(HTRANS_NONSEQ); full = 1'b0;
        step(); bus_idle(); full = 1'b1;
        step(); step(); #1;
        n_cmp++; if (state !== W_STALL) begin n_bad++; $display("FAIL mid_pre_state: got %0d want %0d", state, W_STALL); end
        n_rst = 1'b0; full = 1'b0; #1;
        n_cmp++; if (state !== W_IDLE) begin n_bad++; $display("FAIL mid_state: got %0d want %0d", state, W_IDLE); end
        n_cmp++; if (enq !== 1'b0 || hreadyout !== 1'b1 || hresp !== 1'b0) begin n_bad++; $display("FAIL mid_outputs: got enq=%b hreadyout=%b hresp=%b want 0 1 0", enq, hreadyout, hresp); end
        n_cmp++; if (blk_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_blk_cnt: got %0d want 0", blk_cnt); end
        step(); n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        bus_idle();
        full = 1'b0; empty = 1'b1; framing_error = 1'b0; blk_ready = 1'b0; err_clr = 1'b0;
        test_reset();
        test_single_write();
        test_burst();
        test_backpressure();
        test_watchdog();
        test_framing();
        test_drain_spacing();
        test_cnt_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
